// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, combinational imem lookup and a
// 2-entry {pc, instr} buffer toward decode, with redirect and misalign flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Handshake: decode takes the head when out_valid && out_ready on a rising
  // edge; out_valid never depends on out_ready, and a redirect masks it.

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_mem_q    [2];
  logic [31:0] instr_mem_q [2];

  logic push, pop, tail;

  assign out_valid = (count_q != EMPTY) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count_q != FULL) || pop);
  // With two slots the tail sits one past the head only when exactly one is used.
  assign tail      = head_q ^ (count_q == ONE);

  assign imem_addr    = pc_q;
  assign out_pc       = out_valid ? pc_mem_q[head_q]    : 32'h0;
  assign out_instr    = out_valid ? instr_mem_q[head_q] : 32'h0;
  assign misalign_err = misalign_q;
  assign dbg_state    = count_q;

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      count_d    = EMPTY;
      head_d     = 1'b0;
      misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      if (pop)  head_d = ~head_q;
      case (count_q)
        EMPTY:   if (push) count_d = ONE;
        ONE: begin
          if (push && !pop)      count_d = FULL;
          else if (pop && !push) count_d = EMPTY;
        end
        FULL:    if (pop && !push) count_d = ONE;
        default: count_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      count_q    <= EMPTY;
      head_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      misalign_q <= misalign_d;
    end
  end

  // Payload storage needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[tail]    <= pc_q;
      instr_mem_q[tail] <= imem_instr;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset (word-aligned).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port imem_addr  output  32  byte address to instruction memory; equals fetch PC register.
REQ-005 SHALL have port imem_instr  input  32  instruction word returned combinationally, same cycle, for imem_addr.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port out_valid  output  1  buffered instruction available to decode.
REQ-009 SHALL have port out_ready  input  1  decode accepts the head instruction.
REQ-010 SHALL have port out_instr  output  32  head instruction word.
REQ-011 SHALL have port out_pc  output  32  byte address of head instruction.
REQ-012 SHALL have port misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-013 SHALL hold a 2-entry FIFO of {pc, instr} pairs, with occupancy states EMPTY (0), ONE (1), FULL (2).
REQ-014 SHALL drive out_valid = (count != 0) AND NOT redirect_valid.
REQ-015 SHALL drive out_instr/out_pc from the head entry when out_valid = 1, and 32'h0 when out_valid = 0.
REQ-016 SHALL define pop = out_valid AND out_ready.
REQ-017 SHALL define push = NOT redirect_valid AND (count < 2 OR pop).
REQ-018 SHALL, on push, write {PC, imem_instr} at the FIFO tail and update PC <= PC + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0).
REQ-019 SHALL, when push = 0 and redirect_valid = 0, hold PC (imem_addr stable) and hold FIFO contents.
REQ-020 SHALL treat simultaneous push and pop in FULL as legal: count stays 2, head advances, new entry appended.
REQ-021 SHALL update count as count + push - pop; transitions EMPTY->ONE (push only), ONE->FULL (push only), FULL->ONE (pop only), ONE->EMPTY (pop only), otherwise unchanged.
REQ-022 SHALL give redirect_valid highest priority: FIFO flushed (count <= 0), no push, PC <= {redirect_pc[31:2], 2'b00}.
REQ-023 SHALL set misalign_err <= 1 when redirect_valid = 1 and redirect_pc[1:0] != 0; it stays 1 until reset.
REQ-024 SHALL have a fetch-to-output latency of one cycle: an instruction pushed at edge N is visible on out_* after edge N when it is the head.
REQ-025 SHALL deliver instructions to decode in strictly increasing PC order (mod 2^32) between redirects, with no drop or duplicate.
REQ-026 SHALL keep out_* stable while out_valid = 1 and out_ready = 0 (absent redirect).

Reset
REQ-027 SHALL, on any rising clk with rst = 1, set PC <= RESET_PC, count <= 0, FIFO pointers <= 0, misalign_err <= 0; rst overrides redirect_valid, push and pop.
REQ-028 SHALL, during and immediately after reset, present out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation; the first post-reset output is the instruction at RESET_PC.

Verification
REQ-030 SHALL verify reset: rst = 1 for 2 cycles with a 2-entry-full FIFO -> out_valid = 0, imem_addr = 0, misalign_err = 0; first edge after release pushes mem[0] = 32'h00100093, out_pc = 0.
REQ-031 SHALL verify streaming: out_ready = 1 constantly -> one instruction per cycle, out_pc = 0, 4, 8, 12 with out_instr = 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213.
REQ-032 SHALL verify backpressure: out_ready = 0 from reset -> count reaches FULL after 2 pushes, imem_addr holds at 8, out_pc holds 0; raising out_ready resumes with out_pc = 4, then 8, no gaps.
REQ-033 SHALL verify redirect: redirect_valid = 1, redirect_pc = 32'h40 while FULL -> out_valid = 0 that cycle, FIFO empty, next push is from 32'h40, next output out_pc = 32'h40.
REQ-034 SHALL verify misaligned redirect: redirect_pc = 32'h42 -> PC = 32'h40, misalign_err = 1 and stays 1 across later redirects until rst.
REQ-035 SHALL verify wrap-around: redirect to 32'hFFFF_FFFC with out_ready = 1 -> out_pc sequence 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004.
